fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch front end that produces the pc/instruction pair consumed by the IF/ID pipeline register. It generates sequential PCs and issues requests to instruction memory with a ready handshake. Returned words are buffered in a 2-entry prefetch queue, and one entry per unstalled cycle is presented to IF/ID. Branch/jump redirects squash all fetched-ahead instructions and restart fetch at the target.

Parameters:
PC_RESET, 32'h0000_0000, fetch address after reset (bits [1:0] must be 0)
QDEPTH, 2, prefetch queue depth (fixed at 2; count field 2 bits)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
stall  input  1  hazard stall from the hazard unit; same signal that holds IF/ID
redirect  input  1  taken branch/jump; single-cycle pulse
redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 0
im_req  output  1  instruction memory request
im_addr  output  32  word-aligned request address
im_ready  input  1  memory accepts the request and returns im_rdata in the same cycle
im_rdata  input  32  instruction word, valid when im_req && im_ready
pc_out  output  32  pc of the presented instruction (drives IF/ID pc_in)
inst_out  output  32  presented instruction (drives IF/ID inst_in); 0 = bubble/NOP
fetch_valid  output  1  pc_out/inst_out hold a real instruction

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=PC_RESET, queue count=0, state=IDLE.
  - pc_out=0, inst_out=0, fetch_valid=0; im_req=0, im_addr=PC_RESET.
  - Reset asserted mid-operation discards queue contents and any accepted-but-unqueued word.
- FSM:
  - IDLE: im_req=0 for exactly one cycle after reset release, then FETCH.
  - FETCH: normal operation. No other states.
- Request side (combinational):
  - im_req = (state==FETCH) && (count<2) && !redirect.
  - im_addr = fetch_pc at all times.
  - Handshake completes when im_req && im_ready.
  - On completion at the clock edge: push {fetch_pc, im_rdata} to queue tail, fetch_pc <= fetch_pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - im_ready=0: nothing pushed, fetch_pc holds, im_req stays high (no timeout).
  - stall does not gate requests; fetch continues until the queue is full.
- Output side (registered; priority order):
  1. redirect=1: pc_out<=0, inst_out<=0, fetch_valid<=0; queue cleared (count<=0); fetch_pc<={redirect_pc[31:2],2'b00}. Redirect overrides stall. Nothing is pushed that cycle.
  2. stall=1: pc_out, inst_out, fetch_valid hold; no pop.
  3. count>0: pop head; pc_out<=head.pc, inst_out<=head.inst, fetch_valid<=1.
  4. count==0: bubble (pc_out<=0, inst_out<=0, fetch_valid<=0).
- Queue rules:
  - Push and pop in the same cycle: count unchanged; FIFO order preserved.
  - count==2: im_req=0, so no push; a pop that cycle makes count 1 and re-enables im_req in the next cycle.
  - No bypass: a word is always queued before presentation.
  - Latency: accept at edge N, presented on outputs after edge N+1 if unstalled.
- No other output changes: outputs are stable between edges.

Test Plan:
- Reset/startup: PC_RESET=0x100, im_ready=1, stall=0 -> IDLE 1 cycle; im_addr 0x100,0x104,0x108 on consecutive cycles; pc_out=0x100 with fetch_valid=1 one cycle after the first accept, then 0x104, 0x108 every cycle.
- Memory wait states: im_ready=0 for 3 cycles at addr 0x104 -> im_req and im_addr=0x104 held; bubbles presented (fetch_valid=0, inst_out=0) once queue drains; 0x104 appears one cycle after im_ready=1.
- Stall fill: stall=1 for 5 cycles with im_ready=1 -> outputs frozen; exactly 2 words queued; im_req=0 while full; on release, queued words presented in order with no gap, then fetch resumes.
- Redirect during stall with full queue: redirect=1, redirect_pc=0x2003 -> next cycle outputs bubble, count=0, im_addr=0x2000; 0x2000 presented after accept+1; squashed PCs never appear on pc_out.
- Wrap: PC_RESET=0xFFFF_FFF8 -> im_addr sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Async reset mid-fetch: assert rst between edges with count=2 -> outputs zero immediately; after release, restart at PC_RESET with no stale instruction presented.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, ready-handshaked
// instruction memory requests, a 2-entry prefetch queue and a registered
// pc/instruction pair for the IF/ID register. Redirects squash everything
// fetched ahead and restart at the (word-aligned) target.
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        fetch_valid
);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] q_pc_q   [QDEPTH];
    logic [31:0] q_inst_q [QDEPTH];
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        push, pop;

    // Request side and queue control; outputs and next state with defaults first
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = valid_q;

        // Stall does not gate requests: keep filling until the queue is full.
        im_req  = (state_q == FETCH) && (count_q < 2'd2) && !redirect;
        im_addr = fetch_pc_q;
        push    = im_req && im_ready;
        pop     = !redirect && !stall && (count_q != 2'd0);

        if (state_q == IDLE) state_d = FETCH;

        if (redirect) begin
            // Squash everything fetched ahead; im_req is low so nothing pushes.
            pc_d       = 32'h0;
            inst_d     = 32'h0;
            valid_d    = 1'b0;
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            fetch_pc_d = redirect_pc & ~32'h3;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = ~wr_ptr_q;
            end
            if (stall) begin
                // hold presented pair
            end else if (pop) begin
                pc_d     = q_pc_q[rd_ptr_q];
                inst_d   = q_inst_q[rd_ptr_q];
                valid_d  = 1'b1;
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                pc_d    = 32'h0;
                inst_d  = 32'h0;
                valid_d = 1'b0;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State, fetch PC, queue pointers and presented pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= PC_RESET;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            pc_q       <= 32'h0;
            inst_q     <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
        end
    end

    // Queue storage: write the accepted word at the tail
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc_q[i]   <= 32'h0;
                q_inst_q[i] <= 32'h0;
            end
        end else if (push && !redirect) begin
            q_pc_q[wr_ptr_q]   <= fetch_pc_q;
            q_inst_q[wr_ptr_q] <= im_rdata;
        end
    end

    assign pc_out      = pc_q;
    assign inst_out    = inst_q;
    assign fetch_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Memory returns ~addr as the instruction so
// every presented pc/inst pair can be cross-checked.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect, im_ready;
    logic [31:0] redirect_pc;
    logic        im_req, fetch_valid;
    logic [31:0] im_addr, im_rdata, pc_out, inst_out;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_rdata, w_pc, w_inst;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign im_rdata = ~im_addr;
    assign w_rdata  = ~w_addr;

    fetch_unit #(.PC_RESET(32'h0000_0100), .QDEPTH(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .im_req(im_req), .im_addr(im_addr),
        .im_ready(im_ready), .im_rdata(im_rdata), .pc_out(pc_out),
        .inst_out(inst_out), .fetch_valid(fetch_valid)
    );

    fetch_unit #(.PC_RESET(32'hFFFF_FFF8), .QDEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .im_req(w_req), .im_addr(w_addr),
        .im_ready(im_ready), .im_rdata(w_rdata), .pc_out(w_pc),
        .inst_out(w_inst), .fetch_valid(w_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presented instruction check: valid, pc, and inst = ~pc
    task automatic chk_out(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'h0, fetch_valid}, 32'h1);
        chk({tag, ".pc"},    pc_out,   pc);
        chk({tag, ".inst"},  inst_out, ~pc);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"}, {31'h0, fetch_valid}, 32'h0);
        chk({tag, ".pc"},    pc_out,   32'h0);
        chk({tag, ".inst"},  inst_out, 32'h0);
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"},  {31'h0, im_req}, {31'h0, req});
        chk({tag, ".addr"}, im_addr, addr);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; im_ready = 1'b1;
        #23;
        // Reset state
        chk_bubble("rst");
        chk_req("rst", 1'b0, 32'h100);
        chk("rst.waddr", w_addr, 32'hFFFF_FFF8);

        // Release away from the edge; IDLE for one cycle
        @(posedge clk); #1; rst = 1'b0;
        chk_req("idle", 1'b0, 32'h100);
        step(); // -> FETCH
        chk_req("f0", 1'b1, 32'h100);
        chk_bubble("f0");
        chk("wrap0", w_addr, 32'hFFFF_FFF8);
        step(); // accept 0x100
        chk_req("f1", 1'b1, 32'h104);
        chk_bubble("f1");
        chk("wrap1", w_addr, 32'hFFFF_FFFC);
        step(); // present 0x100, accept 0x104
        chk_out("p100", 32'h100);
        chk_req("f2", 1'b1, 32'h108);
        chk("wrap2", w_addr, 32'h0000_0000);

        // Wait states at 0x108
        im_ready = 1'b0;
        step();
        chk_out("p104", 32'h104);
        chk_req("ws0", 1'b1, 32'h108);
        step();
        chk_bubble("ws1");
        chk_req("ws1", 1'b1, 32'h108);
        step();
        chk_bubble("ws2");
        chk_req("ws2", 1'b1, 32'h108);
        im_ready = 1'b1;
        step(); // accept 0x108
        chk_bubble("ws3");
        chk_req("ws3", 1'b1, 32'h10C);
        step();
        chk_out("p108", 32'h108);
        chk_req("ws4", 1'b1, 32'h110);

        // Stall fill: queue holds 0x10C, fills with 0x110, then req drops
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out("stall", 32'h108);
            chk_req("stall", 1'b0, 32'h114);
        end
        stall = 1'b0;
        step();
        chk_out("p10c", 32'h10C);
        chk_req("rel0", 1'b1, 32'h114);
        step();
        chk_out("p110", 32'h110);
        step();
        chk_out("p114", 32'h114);
        chk_req("rel2", 1'b1, 32'h11C);

        // Redirect during stall with a full queue (0x118, 0x11C)
        stall = 1'b1;
        step();
        chk_out("hold114", 32'h114);
        chk_req("full", 1'b0, 32'h120);
        redirect = 1'b1; redirect_pc = 32'h0000_2003;
        #1;
        chk("redir.req", {31'h0, im_req}, 32'h0);
        step();
        redirect = 1'b0; stall = 1'b0;
        #1;
        chk_bubble("redir");
        chk_req("redir", 1'b1, 32'h2000);
        step(); // accept 0x2000
        chk_bubble("redir1");
        chk_req("redir1", 1'b1, 32'h2004);
        step();
        chk_out("p2000", 32'h2000);

        // Fill queue under stall, then async reset between edges
        stall = 1'b1;
        step();
        chk_req("full2", 1'b0, 32'h200C);
        #2;
        rst = 1'b1;
        #1;
        chk_bubble("arst");
        chk_req("arst", 1'b0, 32'h100);
        @(posedge clk); #1;
        rst = 1'b0; stall = 1'b0;
        chk_req("idle2", 1'b0, 32'h100);
        step();
        chk_req("re0", 1'b1, 32'h100);
        chk_bubble("re0");
        step();
        chk_bubble("re1");
        step();
        chk_out("re100", 32'h100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
